// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and op-classification helpers.
package mdu_pkg;

   typedef enum logic [3:0] {
      MULT  = 4'd1,
      MULTU = 4'd2,
      DIV   = 4'd3,
      DIVU  = 4'd4,
      MADD  = 4'd5,
      MADDU = 4'd6,
      MSUB  = 4'd7,
      MSUBU = 4'd8
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic logic is_valid_op(input logic [3:0] op);
      return (op != 4'd0) && (op <= 4'd8);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_signed(input logic [3:0] op);
      return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
   endfunction

   function automatic logic is_acc(input logic [3:0] op);
      return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
   endfunction

   function automatic logic is_sub(input logic [3:0] op);
      return (op == MSUB) || (op == MSUBU);
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Handshake, operand and HI/LO access bundle between the execute stage and mdu_iter.
interface mdu_iter_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             write;
   logic             dst;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, op, in_a, in_b, write, dst, cancel,
                   input  busy, done, result);
   modport slave  (input  start, op, in_a, in_b, write, dst, cancel,
                   output busy, done, result);
endinterface

// File: rtl/mdu_iter_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and produce the matching quotient bit.
module mdu_div_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qBit
);

   logic [WIDTH:0] w_shifted;

   assign w_shifted = {i_rem, i_bit};
   assign o_qBit    = w_shifted >= {1'b0, i_divisor};
   // The remainder is always below the divisor, so the top bit of the difference is zero.
   assign o_rem     = o_qBit ? WIDTH'(w_shifted - {1'b0, i_divisor}) : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Bit-serial multiply/divide unit with HI/LO registers: WIDTH iteration cycles on
// operand magnitudes, then one fix-up cycle for signs, accumulation and commit.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     reset,
   mdu_iter_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;

   state_e           r_state, w_nextState;
   logic [WIDTH-1:0] r_hi, r_lo, r_a, r_b;
   logic [W2-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;
   logic             r_negRes, r_negRem, r_divZero, r_done;

   logic             w_cancel, w_launch, w_lastIter, w_commit;
   logic             w_aNeg, w_bNeg;
   logic [WIDTH-1:0] w_aMag, w_bMag, w_divRem, w_quot, w_rem;
   logic             w_qBit;
   logic [WIDTH:0]   w_mulSum;
   logic [W2-1:0]    w_mulNext, w_divNext, w_prod, w_hiLoNew;

   // Write outranks cancel and start; cancel only matters while an op is in flight.
   assign w_cancel   = bus.cancel && !bus.write && (r_state != IDLE);
   assign w_launch   = (r_state == IDLE) && bus.start && !bus.write && !bus.cancel
                       && is_valid_op(bus.op);
   assign w_lastIter = (r_cnt == CW'(WIDTH - 1));
   assign w_commit   = (r_state == FIX) && !w_cancel;

   assign w_aNeg = is_signed(bus.op) && bus.in_a[WIDTH-1];
   assign w_bNeg = is_signed(bus.op) && bus.in_b[WIDTH-1];
   assign w_aMag = w_aNeg ? -bus.in_a : bus.in_a;
   assign w_bMag = w_bNeg ? -bus.in_b : bus.in_b;

   // Multiply: multiplier sits in the low half and is consumed LSB first.
   assign w_mulSum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
   assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

   mdu_div_step #(.WIDTH(WIDTH)) u_divStep (
      .i_rem     (r_acc[W2-1:WIDTH]),
      .i_bit     (r_acc[WIDTH-1]),
      .i_divisor (r_b),
      .o_rem     (w_divRem),
      .o_qBit    (w_qBit)
   );

   // Divide: remainder in the high half, dividend shifts out of the low half as quotient shifts in.
   assign w_divNext = {w_divRem, r_acc[WIDTH-2:0], w_qBit};

   always_comb begin
      w_prod    = r_negRes ? -r_acc : r_acc;
      w_quot    = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem     = r_negRem ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
      w_hiLoNew = w_prod;
      if (is_div(r_op)) begin
         w_hiLoNew = {w_rem, w_quot};
      end else if (is_acc(r_op)) begin
         w_hiLoNew = is_sub(r_op) ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_launch) w_nextState = RUN;
         RUN: begin
            if (w_cancel)        w_nextState = IDLE;
            else if (w_lastIter) w_nextState = FIX;
         end
         FIX:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_hi      <= '0;
         r_lo      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_op      <= '0;
         r_negRes  <= 1'b0;
         r_negRem  <= 1'b0;
         r_divZero <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_done  <= w_commit;
         if (w_launch) begin
            r_op      <= bus.op;
            r_a       <= w_aMag;
            r_b       <= w_bMag;
            r_negRes  <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            r_divZero <= (bus.in_b == '0);
            r_cnt     <= '0;
            r_acc     <= is_div(bus.op) ? {{WIDTH{1'b0}}, w_aMag} : {{WIDTH{1'b0}}, w_bMag};
         end else if (r_state == RUN) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= is_div(r_op) ? w_divNext : w_mulNext;
         end
         if (w_commit && !(is_div(r_op) && r_divZero)) begin
            r_hi <= w_hiLoNew[W2-1:WIDTH];
            r_lo <= w_hiLoNew[WIDTH-1:0];
         end
         // A direct write lands after the commit so it wins for its own register.
         if (bus.write) begin
            if (bus.dst) r_hi <= bus.in_a;
            else         r_lo <= bus.in_a;
         end
      end
   end

   assign bus.busy   = (r_state != IDLE);
   assign bus.done   = r_done;
   assign bus.result = bus.dst ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at WIDTH=32 and WIDTH=8.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checkCount = 0;
   int   errorCount = 0;

   mdu_iter_if #(.WIDTH(32)) m32 ();
   mdu_iter_if #(.WIDTH(8))  s8 ();

   mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(m32));
   mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(s8));

   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      m32.start = 1'b1;
      m32.op    = op;
      m32.in_a  = a;
      m32.in_b  = b;
      @(posedge clk);
      #1 m32.start = 1'b0;
   endtask

   task automatic checkHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
      m32.dst = 1'b1;
      #1 checkOutput({tag, " HI"}, m32.result, expHi);
      m32.dst = 1'b0;
      #1 checkOutput({tag, " LO"}, m32.result, expLo);
   endtask

   // Counts busy cycles after the accepting edge, then checks a single done pulse.
   task automatic waitIdle(input string tag, input int expCycles);
      int cycles = 0;
      int earlyDone = 0;
      @(negedge clk);
      while (m32.busy && cycles < 200) begin
         if (m32.done) earlyDone++;
         cycles++;
         @(negedge clk);
      end
      if (expCycles >= 0) checkOutput({tag, " busy cycles"}, 64'(cycles), 64'(expCycles));
      checkOutput({tag, " done pulse"}, 64'(m32.done), 64'd1);
      @(negedge clk);
      checkOutput({tag, " done single"}, 64'(m32.done) + 64'(earlyDone), 64'd0);
   endtask

   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
      applyStimulus(op, a, b);
      waitIdle(tag, 33);
      checkHiLo(tag, expHi, expLo);
   endtask

   initial begin
      int cycles8;
      int earlyDone8;
      m32.start = 1'b0; m32.op = 4'd0; m32.in_a = '0; m32.in_b = '0;
      m32.write = 1'b0; m32.dst = 1'b0; m32.cancel = 1'b0;
      s8.start = 1'b0; s8.op = 4'd0; s8.in_a = '0; s8.in_b = '0;
      s8.write = 1'b0; s8.dst = 1'b0; s8.cancel = 1'b0;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset busy", 64'(m32.busy), 64'd0);
      checkOutput("reset done", 64'(m32.done), 64'd0);
      checkHiLo("reset", 32'h0, 32'h0);

      runOp("MULT -3*7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      runOp("MULTU", MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
      runOp("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("DIV MIN/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      runOp("DIVU 7/0", DIVU, 32'd7, 32'd0, 32'h0, 32'h8000_0000);

      @(negedge clk);
      m32.write = 1'b1; m32.dst = 1'b0; m32.in_a = 32'hFFFF_FFFF;
      @(negedge clk);
      m32.dst = 1'b1; m32.in_a = 32'h0;
      @(negedge clk);
      m32.write = 1'b0;
      checkHiLo("write setup", 32'h0, 32'hFFFF_FFFF);

      runOp("MADDU 1*1", MADDU, 32'd1, 32'd1, 32'h1, 32'h0);
      runOp("MSUB 1*1", MSUB, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF);

      applyStimulus(MULT, 32'd5, 32'd5);
      repeat (9) @(negedge clk);
      checkOutput("cancel pre busy", 64'(m32.busy), 64'd1);
      m32.cancel = 1'b1;
      @(posedge clk);
      #1 m32.cancel = 1'b0;
      @(negedge clk);
      checkOutput("cancel busy", 64'(m32.busy), 64'd0);
      checkOutput("cancel done", 64'(m32.done), 64'd0);
      checkHiLo("cancel", 32'h0, 32'hFFFF_FFFF);
      runOp("MULT after cancel", MULT, 32'd5, 32'd5, 32'h0, 32'd25);

      applyStimulus(MULT, 32'd2, 32'd3);
      repeat (3) @(negedge clk);
      m32.write = 1'b1; m32.dst = 1'b0; m32.in_a = 32'h1234;
      @(posedge clk);
      #1 m32.write = 1'b0;
      @(negedge clk);
      checkOutput("write mid result", 64'(m32.result), 64'h1234);
      checkOutput("write mid busy", 64'(m32.busy), 64'd1);
      waitIdle("write mid", -1);
      checkHiLo("write mid commit", 32'h0, 32'd6);

      @(negedge clk);
      m32.write = 1'b1; m32.start = 1'b1; m32.dst = 1'b1;
      m32.op = MULT; m32.in_a = 32'hABCD; m32.in_b = 32'd2;
      @(posedge clk);
      #1 m32.write = 1'b0; m32.start = 1'b0;
      @(negedge clk);
      checkOutput("write+start busy", 64'(m32.busy), 64'd0);
      checkHiLo("write+start", 32'hABCD, 32'd6);

      applyStimulus(4'd9, 32'd1, 32'd1);
      @(negedge clk);
      checkOutput("bad op busy", 64'(m32.busy), 64'd0);

      applyStimulus(DIV, 32'd100, 32'd7);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("mid reset busy", 64'(m32.busy), 64'd0);
      checkOutput("mid reset done", 64'(m32.done), 64'd0);
      checkHiLo("mid reset", 32'h0, 32'h0);

      @(negedge clk);
      s8.start = 1'b1; s8.op = MULT; s8.in_a = 8'h80; s8.in_b = 8'h80;
      @(posedge clk);
      #1 s8.start = 1'b0;
      cycles8 = 0;
      earlyDone8 = 0;
      @(negedge clk);
      while (s8.busy && cycles8 < 100) begin
         if (s8.done) earlyDone8++;
         cycles8++;
         @(negedge clk);
      end
      checkOutput("W8 busy cycles", 64'(cycles8), 64'd9);
      checkOutput("W8 done pulse", 64'(s8.done) + 64'(earlyDone8), 64'd1);
      s8.dst = 1'b1;
      #1 checkOutput("W8 HI", 64'(s8.result), 64'h40);
      s8.dst = 1'b0;
      #1 checkOutput("W8 LO", 64'(s8.result), 64'h00);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO registers, the next-generation replacement for the fixed-latency HI/LO unit in the pipelined CPU's execute stage. It computes signed/unsigned multiply, multiply-accumulate/subtract, and divide with true bit-serial datapaths instead of single-cycle operators. It exposes a start/busy/done handshake, an abort input for exception flush, and a direct HI/LO write path for MTHI/MTLO. The stall unit holds any HI/LO-dependent instruction in decode while `busy` or `start` is high.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥4 and even.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: launch the operation in `op`; accepted only when `busy`=0.
- `op` in 4: operation code from `mdu_pkg`: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- `in_a` in WIDTH: rs operand, or data for an HI/LO write.
- `in_b` in WIDTH: rt operand.
- `write` in 1: write `in_a` into HI (`dst`=1) or LO (`dst`=0).
- `dst` in 1: selects HI (1) or LO (0) for both `write` and `result`.
- `cancel` in 1: abort the in-flight operation (exception/flush).
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse on the cycle after HI/LO commit.
- `result` out WIDTH: combinational `dst ? HI : LO`.

## Operation
- Reset values: HI=0, LO=0, `busy`=0, `done`=0, FSM in IDLE, iteration counter 0, all scratch registers 0.
- FSM states:
  - IDLE -> RUN on `start` && !`busy` && !`write`. Latches operands as magnitudes for signed ops, latches the result signs, and clears the counter.
  - RUN: one iteration per cycle for WIDTH cycles.
    - Multiply: shift-add on a 2·WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - RUN -> FIX after iteration WIDTH-1.
  - FIX: applies sign correction, applies accumulate/subtract, commits HI/LO, then -> IDLE.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = a·b, 2·WIDTH-bit signed or unsigned product.
  - MADD(U)/MSUB(U): {HI,LO} = {HI,LO} ± a·b, modulo 2^(2·WIDTH). HI/LO are sampled in FIX, not at start.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0. No trap.
  - Divide by zero (`in_b`=0): full latency runs, HI/LO unchanged, `done` still pulses.
- Priority, highest first: `reset`, `write`, `cancel`, `start`.
  - `write` while busy: updates the register immediately. The in-flight op continues and its FIX overwrites the register.
  - `write` with `start` in the same cycle: write performed, start dropped.
  - `cancel` in RUN/FIX: -> IDLE next edge, `busy`=0, HI/LO unchanged, no `done`.
  - `cancel` in IDLE: ignored. `cancel` with `start` while idle: start dropped.
- `start` while busy is ignored; no queueing.
- Unknown `op` with `start`: ignored, stays IDLE.

## Timing
- Edge E0 accepts `start`. `busy`=1 from E0 through E(WIDTH+1).
- HI/LO commit at E(WIDTH+1). At that edge `busy` falls and `done` rises for one cycle.
- Total latency is WIDTH+1 cycles for every op (33 at WIDTH=32). A new `start` is accepted in the cycle after E(WIDTH+1), i.e. at edge E(WIDTH+2).
- `result` is combinational and reflects a write or commit in the cycle after the edge that performed it.
- Reset asserted mid-operation clears everything at that edge. No `done` is produced.

## Structure
- `mdu_pkg` holds:
  - op encoding enum: MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8;
  - FSM state enum: IDLE, RUN, FIX;
  - helpers `is_div(op)`, `is_signed(op)`, `is_acc(op)`.
- One sub-module, `mdu_div_step`: combinational single restoring-divide step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder and quotient bit.
  - Instantiated once in `mdu_iter`. Multiply stays inline.

## Test plan
- MULT a=-3 (0xFFFFFFFD), b=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulses once. MULTU, same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 7/0 -> HI/LO unchanged, `busy` still 33 cycles.
- HI=0, LO=0xFFFFFFFF, MADDU a=1, b=1 -> HI=1, LO=0. Then MSUB a=1, b=1 -> HI=0, LO=0xFFFFFFFF.
- Start MULT 5·5, `cancel` at cycle 10 -> `busy`=0 at next edge, HI/LO keep previous values, no `done`. A new start the next cycle completes normally.
- `write` with `dst`=0, `in_a`=0x1234 during a MULT of 2·3 -> `result`=0x1234 the next cycle, then LO=6 after commit. Simultaneous `write`+`start` -> only the write takes effect, `busy` stays 0.
- `reset` at cycle 20 of a DIV -> all outputs 0 next cycle. Repeat with WIDTH=8: MULT 0x80·0x80 -> HI=0x40, LO=0x00, `busy` 9 cycles.
